// File: rtl/fft_wrapper.sv
// fft_wrapper
// 8-point radix-2 decimation-in-time FFT. One frame of complex samples is
// streamed in, transformed in place over three butterfly stages, and the
// eight bins are then presented one per cycle, tagged with their index.
// Every butterfly halves its result, so each bin equals DFT(x)[k] / 8.
//
// Ports
//   clk_i          single clock, all logic on the rising edge
//   reset          asynchronous, active-high reset
//   tvalid         input sample valid
//   signal         input complex sample, [49:25] real, [24:0] imag (signed)
//   tlast          marks the final sample of a frame (may close it early)
//   tready         high while the core is accepting samples
//   final_stage    output bin X[k], same packing as signal
//   final_num_top  bin index k of final_stage
module fft_wrapper #(
  parameter int SIGNAL_COUNT = 7,
  parameter int SIGNAL_SIZE  = 50
) (
  input  logic                   clk_i,
  input  logic                   reset,
  input  logic                   tvalid,
  input  logic [SIGNAL_SIZE-1:0] signal,
  input  logic                   tlast,
  output logic                   tready,
  output logic [SIGNAL_SIZE-1:0] final_stage,
  output logic [2:0]             final_num_top
);

  typedef enum logic [2:0] {LOAD, ST1, ST2, ST3, OUT} state_t;

  // Real part occupies the upper half, matching the port packing.
  typedef struct packed {
    logic [24:0] re;
    logic [24:0] im;
  } cplx_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  out_idx;
  cplx_t       mem [8];
  cplx_t       nxt [8];

  // Multiply by twiddle W8^k (Q1.14), keeping full precision until the
  // final truncating shift back to 25 bits.
  function automatic cplx_t cmul(input cplx_t b, input logic [1:0] k);
    logic signed [15:0] wr;
    logic signed [15:0] wi;
    logic signed [41:0] pr;
    logic signed [41:0] pi;
    cplx_t              res;
    case (k)
      2'd0:    begin wr = 16'sd16384;  wi = 16'sd0;      end
      2'd1:    begin wr = 16'sd11585;  wi = -16'sd11585; end
      2'd2:    begin wr = 16'sd0;      wi = -16'sd16384; end
      default: begin wr = -16'sd11585; wi = -16'sd11585; end
    endcase
    pr = $signed(b.re) * wr - $signed(b.im) * wi;
    pi = $signed(b.re) * wi + $signed(b.im) * wr;
    res.re = 25'(pr >>> 14);
    res.im = 25'(pi >>> 14);
    return res;
  endfunction

  // Half of (a + t) or (a - t); the arithmetic shift floors toward -inf.
  function automatic cplx_t bsum(input cplx_t a, input cplx_t t, input logic sub);
    logic signed [25:0] r;
    logic signed [25:0] i;
    cplx_t              res;
    if (sub) begin
      r = $signed({a.re[24], a.re}) - $signed({t.re[24], t.re});
      i = $signed({a.im[24], a.im}) - $signed({t.im[24], t.im});
    end else begin
      r = $signed({a.re[24], a.re}) + $signed({t.re[24], t.re});
      i = $signed({a.im[24], a.im}) + $signed({t.im[24], t.im});
    end
    res.re = 25'(r >>> 1);
    res.im = 25'(i >>> 1);
    return res;
  endfunction

  // Next contents of the sample RAM for the current butterfly stage.
  // Samples are stored bit-reversed, so each stage pairs fixed slots and
  // the last stage leaves the bins in natural order.
  always_comb begin
    nxt = mem;
    case (state)
      ST1: begin
        for (int p = 0; p < 4; p++) begin
          nxt[3'(2*p)]   = bsum(mem[3'(2*p)], cmul(mem[3'(2*p+1)], 2'd0), 1'b0);
          nxt[3'(2*p+1)] = bsum(mem[3'(2*p)], cmul(mem[3'(2*p+1)], 2'd0), 1'b1);
        end
      end
      ST2: begin
        for (int p = 0; p < 4; p++) begin
          nxt[3'((p/2)*4 + p%2)]     = bsum(mem[3'((p/2)*4 + p%2)],
                                            cmul(mem[3'((p/2)*4 + p%2 + 2)], 2'((p%2)*2)), 1'b0);
          nxt[3'((p/2)*4 + p%2 + 2)] = bsum(mem[3'((p/2)*4 + p%2)],
                                            cmul(mem[3'((p/2)*4 + p%2 + 2)], 2'((p%2)*2)), 1'b1);
        end
      end
      ST3: begin
        for (int p = 0; p < 4; p++) begin
          nxt[3'(p)]   = bsum(mem[3'(p)], cmul(mem[3'(p+4)], 2'(p)), 1'b0);
          nxt[3'(p+4)] = bsum(mem[3'(p)], cmul(mem[3'(p+4)], 2'(p)), 1'b1);
        end
      end
      default: ;
    endcase
  end

  // Frame control: load samples, run three stages, then stream the bins.
  // The RAM is cleared on the way back to LOAD so an early-closed frame
  // sees zeros in its unfilled slots.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state         <= LOAD;
      cnt           <= 3'd0;
      out_idx       <= 3'd0;
      mem           <= '{default: '0};
      tready        <= 1'b1;
      final_stage   <= '0;
      final_num_top <= 3'd0;
    end else begin
      case (state)
        LOAD: begin
          if (tvalid && tready) begin
            mem[{cnt[0], cnt[1], cnt[2]}] <= signal;
            if (cnt == 3'(SIGNAL_COUNT) || tlast) begin
              state  <= ST1;
              tready <= 1'b0;
              cnt    <= 3'd0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        ST1: begin
          mem   <= nxt;
          state <= ST2;
        end
        ST2: begin
          mem   <= nxt;
          state <= ST3;
        end
        ST3: begin
          mem     <= nxt;
          out_idx <= 3'd0;
          state   <= OUT;
        end
        OUT: begin
          final_stage   <= mem[out_idx];
          final_num_top <= out_idx;
          out_idx       <= out_idx + 3'd1;
          if (out_idx == 3'd7) begin
            state  <= LOAD;
            tready <= 1'b1;
            cnt    <= 3'd0;
            mem    <= '{default: '0};
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_wrapper.sv
// tb_fft_wrapper
// Table-driven frames with hand-derived bins, checked through an expected
// queue, plus hand-written reset sequences.
module tb_fft_wrapper;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        tvalid;
  logic [49:0] signal;
  logic        tlast;
  logic        tready;
  logic [49:0] final_stage;
  logic [2:0]  final_num_top;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0][49:0] samp;
    int               len;
    logic [7:0][49:0] expv;
    logic             bp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [49:0] val;
  } exp_t;

  vec_t vecs [5];
  exp_t sb [$];

  fft_wrapper #(.SIGNAL_COUNT(7), .SIGNAL_SIZE(50)) dut (
    .clk_i         (clk_i),
    .reset         (reset),
    .tvalid        (tvalid),
    .signal        (signal),
    .tlast         (tlast),
    .tready        (tready),
    .final_stage   (final_stage),
    .final_num_top (final_num_top)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [49:0] cx(input int re, input int im);
    return {re[24:0], im[24:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one frame (tlast on its last sample) and queue its bins.
  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      check("tready_load", 64'(tready), 64'd1);
      tvalid = 1'b1;
      signal = v.samp[i];
      tlast  = (i == v.len - 1);
      @(posedge clk_i);
      #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    for (int k = 0; k < 8; k++) sb.push_back('{k, v.expv[k]});
  endtask

  // Walk the eleven edges after the closing edge; bins come after edges 4..11.
  task automatic checkOutput(input logic bp);
    exp_t e;
    for (int n = 1; n <= 11; n++) begin
      if (bp) begin
        tvalid = 1'b1;
        signal = {$urandom, $urandom} & 50'h3ffff_ffff_ffff;
        tlast  = 1'($urandom_range(0, 1));
      end
      @(posedge clk_i);
      #1;
      if (n < 11) check("tready_busy", 64'(tready), 64'd0);
      if (n >= 4) begin
        if (sb.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("bin%0d", e.idx), {11'd0, final_num_top, final_stage},
                {11'd0, 3'(e.idx), e.val});
        end
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    check("tready_back", 64'(tready), 64'd1);
  endtask

  initial begin
    reset  = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    signal = '0;

    // DC
    vecs[0].len = 8; vecs[0].bp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vecs[0].samp[i] = cx(100, 0);
      vecs[0].expv[i] = cx(0, 0);
    end
    vecs[0].expv[0] = cx(100, 0);
    // Impulse at x0
    vecs[1].len = 8; vecs[1].bp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vecs[1].samp[i] = cx(0, 0);
      vecs[1].expv[i] = cx(100, 0);
    end
    vecs[1].samp[0] = cx(800, 0);
    // Alternating, with junk driven during processing
    vecs[2].len = 8; vecs[2].bp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vecs[2].samp[i] = cx((i % 2 == 1) ? -80 : 80, 0);
      vecs[2].expv[i] = cx(0, 0);
    end
    vecs[2].expv[4] = cx(80, 0);
    // Impulse at x1: 100*W8^k, truncated
    vecs[3].len = 8; vecs[3].bp = 1'b0;
    for (int i = 0; i < 8; i++) vecs[3].samp[i] = cx(0, 0);
    vecs[3].samp[1] = cx(800, 0);
    vecs[3].expv[0] = cx(100, 0);  vecs[3].expv[1] = cx(70, -71);
    vecs[3].expv[2] = cx(0, -100); vecs[3].expv[3] = cx(-71, -71);
    vecs[3].expv[4] = cx(-100, 0); vecs[3].expv[5] = cx(-71, 71);
    vecs[3].expv[6] = cx(0, 100);  vecs[3].expv[7] = cx(71, 71);
    // Early tlast on the third sample
    vecs[4].len = 3; vecs[4].bp = 1'b0;
    for (int i = 0; i < 8; i++) vecs[4].samp[i] = cx(i < 3 ? 8 : 0, 0);
    vecs[4].expv[0] = cx(3, 0); vecs[4].expv[1] = cx(1, -2);
    vecs[4].expv[2] = cx(0, -1); vecs[4].expv[3] = cx(0, 0);
    vecs[4].expv[4] = cx(1, 0); vecs[4].expv[5] = cx(0, 0);
    vecs[4].expv[6] = cx(0, 1); vecs[4].expv[7] = cx(2, 2);

    #12;
    check("rst_stage", 64'(final_stage), 64'd0);
    check("rst_num", 64'(final_num_top), 64'd0);
    check("rst_tready", 64'(tready), 64'd1);
    reset = 1'b0;
    @(posedge clk_i);
    #1;

    for (int v = 0; v < 5; v++) begin
      $display("[TB] frame %0d", v);
      applyStimulus(vecs[v]);
      checkOutput(vecs[v].bp);
    end

    // Reset after four accepted samples of a DC frame.
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1;
      signal = cx(100, 0);
      tlast  = 1'b0;
      @(posedge clk_i);
      #1;
    end
    tvalid = 1'b0;
    #1;
    reset = 1'b1;
    #2;
    check("midframe_stage", 64'(final_stage), 64'd0);
    check("midframe_num", 64'(final_num_top), 64'd0);
    check("midframe_tready", 64'(tready), 64'd1);
    reset = 1'b0;
    @(posedge clk_i);
    #1;
    // Stale samples would corrupt this short frame.
    applyStimulus(vecs[4]);
    checkOutput(1'b0);
    applyStimulus(vecs[0]);
    checkOutput(1'b0);

    // Reset partway through the output phase.
    $display("[TB] reset mid-output");
    applyStimulus(vecs[1]);
    repeat (6) @(posedge clk_i);
    #1;
    reset = 1'b1;
    #2;
    check("midout_stage", 64'(final_stage), 64'd0);
    check("midout_num", 64'(final_num_top), 64'd0);
    check("midout_tready", 64'(tready), 64'd1);
    sb.delete();
    reset = 1'b0;
    @(posedge clk_i);
    #1;
    applyStimulus(vecs[0]);
    checkOutput(1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
